// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_rd_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned LEN_WIDTH_DEF  = 8;
  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned REQ_ICACHE     = 0;
  localparam int unsigned REQ_DCACHE     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester-side and AXI AR/R signals of the read arbiter, bundled as one interface.
interface axi_rd_arbiter_if
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);

  logic [NUM_REQ-1:0]                 s_req;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] s_addr;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  s_len;
  logic [NUM_REQ-1:0]                 s_ready;
  logic [NUM_REQ-1:0]                 s_rvalid;
  logic [NUM_REQ-1:0]                 s_rready;
  logic [DATA_WIDTH-1:0]              s_rdata;
  logic                               s_rlast;
  logic                               s_rerr;

  logic                               m_arvalid;
  logic                               m_arready;
  logic [ADDR_WIDTH-1:0]              m_araddr;
  logic [LEN_WIDTH-1:0]               m_arlen;
  logic                               m_arid;

  logic                               m_rvalid;
  logic                               m_rready;
  logic [DATA_WIDTH-1:0]              m_rdata;
  logic [1:0]                         m_rresp;
  logic                               m_rlast;
  logic                               m_rid;

  // Arbiter view
  modport master (
    input  s_req, s_addr, s_len, s_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_ready, s_rvalid, s_rdata, s_rlast, s_rerr,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  // Environment view (requesters plus AXI slave)
  modport slave (
    output s_req, s_addr, s_len, s_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s_ready, s_rvalid, s_rdata, s_rlast, s_rerr,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time gets the grant.
module rr_arbiter2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant_c
);

  always_comb begin
    grant_c = req;
    if (&req) begin
      grant_c = '0;
      if (last_grant) grant_c[REQ_ICACHE] = 1'b1;
      else            grant_c[REQ_DCACHE] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates ICache/DCache read bursts onto one AXI read port, one burst outstanding,
// with zero-cycle R pass-through and a sticky burst-length mismatch flag.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
)(
  input  logic                clk,
  input  logic                rst,
  axi_rd_arbiter_if.master    bus,
  output logic                proto_err
);

  localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_REQ-1:0]    grant_c;
  logic                  gnt_idx_c;
  logic                  rready_c;
  logic                  beat_c;
  logic                  len_hit_c;
  logic                  g_q;
  logic                  last_grant_q;
  logic                  proto_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  unused_rid;

  // The burst owner is latched at grant time, so the returned ID carries no information.
  assign unused_rid = bus.m_rid;

  rr_arbiter2 u_rr (
    .req        (bus.s_req),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  assign gnt_idx_c = grant_c[REQ_DCACHE];
  assign rready_c  = bus.s_rready[g_q];
  assign beat_c    = (state_q == DATA) && bus.m_rvalid && rready_c;
  assign len_hit_c = (cnt_q == CNT_WIDTH'(len_q));

  assign bus.m_araddr = addr_q;
  assign bus.m_arlen  = len_q;
  assign bus.m_arid   = g_q;
  assign proto_err    = proto_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant_c)                  state_d = ADDR;
      ADDR:    if (bus.m_arready)             state_d = DATA;
      DATA:    if (beat_c && bus.m_rlast)     state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // s_ready is masked by rst so every output reads zero while reset is held.
  always_comb begin
    bus.s_ready   = '0;
    bus.s_rvalid  = '0;
    bus.s_rdata   = '0;
    bus.s_rlast   = 1'b0;
    bus.s_rerr    = 1'b0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    case (state_q)
      IDLE: if (rst) bus.s_ready = grant_c;
      ADDR: bus.m_arvalid = 1'b1;
      DATA: begin
        bus.m_rready        = rready_c;
        bus.s_rvalid[g_q]   = bus.m_rvalid;
        bus.s_rdata         = DATA_WIDTH'(bus.m_rdata);
        bus.s_rlast         = bus.m_rlast;
        bus.s_rerr          = (bus.m_rresp != 2'd0);
      end
      default: ;
    endcase
  end

  // Request latch, beat counter, round-robin history and length checking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      len_q        <= '0;
      g_q          <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (|grant_c)) begin
        addr_q <= bus.s_addr[gnt_idx_c];
        len_q  <= bus.s_len[gnt_idx_c];
        g_q    <= gnt_idx_c;
      end
      if ((state_q == ADDR) && bus.m_arready) cnt_q <= '0;
      if (beat_c) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
        if (bus.m_rlast) last_grant_q <= g_q;
        // The beat numbered len must be the last one, and only that one.
        if (bus.m_rlast != len_hit_c) proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed scenarios followed by randomized bursts.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          id;
  } ar_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic proto_err;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .proto_err (proto_err)
  );

  ar_t   ar_q[$];
  beat_t beat_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  cur_g = 1'b0;
  bit    in_data = 1'b0;
  int    rr_hold = 0;
  bit    rand_rr = 1'b0;
  logic  mdl_last = 1'b1;
  logic  mdl_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({bus.s_ready, bus.s_rvalid, bus.s_rlast, bus.s_rerr,
                             bus.m_arvalid, bus.m_arid, bus.m_rready, proto_err}), 64'd0);
    chk({tag, "_bus"},  64'({bus.m_araddr, bus.s_rdata}), 64'd0);
    chk({tag, "_len"},  64'(bus.m_arlen), 64'd0);
  endtask

  // Requester back-pressure: forced low for rr_hold cycles, otherwise random or always ready.
  initial begin
    bus.s_rready = 2'b11;
    forever begin
      @(posedge clk);
      #2;
      if (rr_hold > 0) begin
        bus.s_rready = 2'b00;
        rr_hold--;
      end else if (rand_rr) begin
        bus.s_rready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      end else begin
        bus.s_rready = 2'b11;
      end
    end
  end

  // Monitor: pops expected AR requests and beats as the DUT presents them.
  initial begin
    ar_t   ea;
    beat_t eb;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (bus.m_arvalid && bus.m_arready) begin
          if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
          else begin
            ea = ar_q.pop_front();
            chk("m_araddr", 64'(bus.m_araddr), 64'(ea.addr));
            chk("m_arlen",  64'(bus.m_arlen),  64'(ea.len));
            chk("m_arid",   64'(bus.m_arid),   64'(ea.id));
          end
        end
        if (in_data) begin
          chk("m_rready_follow", 64'(bus.m_rready), 64'(bus.s_rready[cur_g]));
          chk("s_rvalid_route", 64'(bus.s_rvalid), bus.m_rvalid ? (64'd1 << cur_g) : 64'd0);
          if (bus.m_rvalid && bus.s_rready[cur_g]) begin
            if (beat_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
            else begin
              eb = beat_q.pop_front();
              chk("s_rdata", 64'(bus.s_rdata), 64'(eb.data));
              chk("s_rlast", 64'(bus.s_rlast), 64'(eb.last));
              chk("s_rerr",  64'(bus.s_rerr),  64'(eb.err));
            end
          end
        end else begin
          chk("s_rvalid_outside", 64'(bus.s_rvalid), 64'd0);
        end
      end
    end
  end

  // One burst: request, AR phase (optionally stalled), R beats with rlast at len+delta.
  task automatic run_burst(input logic [1:0] req, input logic [1:0][AW-1:0] addr,
                           input logic [1:0][LW-1:0] len, input int arstall, input int delta,
                           input bit hold, input bit rstall, input int abort_at);
    logic  w;
    ar_t   e;
    beat_t b;
    bit    hs;
    int    nb;
    int    r;
    w = (req == 2'b11) ? ~mdl_last : req[1];
    bus.s_req  = req;
    bus.s_addr = addr;
    bus.s_len  = len;
    e.addr = addr[w];
    e.len  = len[w];
    e.id   = w;
    ar_q.push_back(e);
    cur_g = w;
    #1;
    chk("s_ready_grant", 64'(bus.s_ready), 64'd1 << w);
    @(posedge clk);
    #1;
    if (!hold) bus.s_req = 2'b00;
    bus.s_addr = {$urandom, $urandom};
    bus.s_len  = 16'($urandom);
    bus.m_arready = 1'b0;
    repeat (arstall) begin
      @(negedge clk);
      chk("arvalid_stall", 64'(bus.m_arvalid), 64'd1);
      chk("ar_stable", 64'({bus.m_araddr, bus.m_arlen, bus.m_arid}), 64'({addr[w], len[w], w}));
      chk("no_second_ready", 64'(bus.s_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.m_arready = 1'b1;
    hs = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk);
      hs = bus.m_arvalid;
      @(posedge clk);
      #1;
    end
    bus.m_arready = 1'b0;
    if (!hs) begin
      chk("ar_timeout", 64'd0, 64'd1);
      return;
    end
    in_data = 1'b1;
    nb = int'(len[w]) + delta + 1;
    if (nb < 1) nb = 1;
    if (nb - 1 != int'(len[w])) mdl_err = 1'b1;
    for (int i = 0; i < nb; i++) begin
      bus.m_rvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if (rstall && i == 1) rr_hold = 3;
      r = $urandom_range(0, 7);
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = $urandom;
      bus.m_rresp  = (r < 5) ? 2'd0 : 2'(r - 4);
      bus.m_rlast  = (i == nb - 1);
      bus.m_rid    = 1'($urandom);
      b.data = bus.m_rdata;
      b.last = bus.m_rlast;
      b.err  = (bus.m_rresp != 2'd0);
      beat_q.push_back(b);
      hs = 1'b0;
      for (int n = 0; n < 100 && !hs; n++) begin
        @(negedge clk);
        hs = bus.m_rready;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        chk("beat_timeout", 64'd0, 64'd1);
        bus.m_rvalid = 1'b0;
        in_data = 1'b0;
        return;
      end
      if (i == abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_burst");
        in_data      = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_req    = 2'b00;
        ar_q.delete();
        beat_q.delete();
        mdl_last = 1'b1;
        mdl_err  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    in_data      = 1'b0;
    mdl_last     = w;
    @(negedge clk);
    chk("proto_err", 64'(proto_err), 64'(mdl_err));
    chk("idle_quiet", 64'({bus.m_arvalid, bus.m_rready}), 64'd0);
    chk("beats_drained", 64'(beat_q.size()), 64'd0);
  endtask

  initial begin
    logic [1:0][AW-1:0] a;
    logic [1:0][LW-1:0] l;
    int                 r;
    rst           = 1'b0;
    bus.s_req     = 2'b11;
    bus.s_addr    = {32'h1111_2222, 32'h3333_4444};
    bus.s_len     = {8'd5, 8'd6};
    bus.m_arready = 1'b1;
    bus.m_rvalid  = 1'b1;
    bus.m_rdata   = 32'hDEAD_BEEF;
    bus.m_rresp   = 2'd2;
    bus.m_rlast   = 1'b1;
    bus.m_rid     = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    bus.s_req     = 2'b00;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rresp   = 2'd0;
    bus.m_rlast   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_no_req", 64'({bus.s_ready, bus.m_arvalid}), 64'd0);

    // Tie out of reset goes to ICache, then DCache with s_req still both set.
    a = {32'h4000_1000, 32'h2000_0040};
    l = {8'd3, 8'd3};
    run_burst(2'b11, a, l, 0, 0, 1'b1, 1'b0, -1);
    run_burst(2'b11, a, l, 0, 0, 1'b0, 1'b0, -1);

    // Basic ICache 4-beat burst.
    a = {32'h0000_0000, 32'h8000_0000};
    l = {8'd0, 8'd3};
    run_burst(2'b01, a, l, 0, 0, 1'b0, 1'b0, -1);

    // AR channel held off for 5 cycles.
    a = {32'hCAFE_0000, 32'h0BAD_F00D};
    l = {8'd2, 8'd3};
    run_burst(2'b10, a, l, 5, 0, 1'b0, 1'b0, -1);

    // Requester back-pressure mid-burst.
    l = {8'd3, 8'd3};
    run_burst(2'b10, a, l, 0, 0, 1'b0, 1'b1, -1);

    // Early rlast on beat 2 of a 4-beat burst sets the sticky error.
    run_burst(2'b01, a, l, 1, -2, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // Reset after the first beat, then a clean burst.
    run_burst(2'b10, a, l, 0, 0, 1'b0, 1'b0, 0);
    run_burst(2'b10, a, l, 0, 0, 1'b0, 1'b0, -1);

    rand_rr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom};
      l = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      r = $urandom_range(0, 9);
      run_burst(2'($urandom_range(1, 3)), a, l, $urandom_range(0, 3),
                (r == 0) ? -1 : ((r == 1) ? 1 : 0), 1'($urandom), 1'b0, -1);
    end
    bus.s_req = 2'b00;
    rand_rr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", 64'({bus.s_ready, bus.m_arvalid, bus.m_rready}), 64'd0);
    chk("final_queues", 64'(ar_q.size() + beat_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, physical address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI read data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, AXI burst length width (beats minus one).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port s_req  input  2  per-requester read request (bit0 ICache, bit1 DCache).
REQ-008 SHALL have port s_addr  input  2xADDR_WIDTH  per-requester burst start address.
REQ-009 SHALL have port s_len  input  2xLEN_WIDTH  per-requester burst length minus one.
REQ-010 SHALL have port s_ready  output  2  request accepted this cycle (one-hot or zero).
REQ-011 SHALL have port s_rvalid  output  2  read beat valid to requester.
REQ-012 SHALL have port s_rready  input  2  requester can take a beat.
REQ-013 SHALL have ports s_rdata (output, DATA_WIDTH), s_rlast (output, 1) and s_rerr (output, 1), shared beat data, last flag and error flag, meaningful only where s_rvalid is set.
REQ-014 SHALL have ports m_arvalid (output, 1), m_arready (input, 1), m_araddr (output, ADDR_WIDTH), m_arlen (output, LEN_WIDTH) and m_arid (output, 1), forming the AXI AR channel.
REQ-015 SHALL have ports m_rvalid (input, 1), m_rready (output, 1), m_rdata (input, DATA_WIDTH), m_rresp (input, 2), m_rlast (input, 1) and m_rid (input, 1), forming the AXI R channel.
REQ-016 SHALL have port proto_err  output  1  sticky burst-length mismatch flag.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with only one burst outstanding.
REQ-018 IDLE: with no s_req bit set, SHALL stay in IDLE with s_ready=0.
REQ-019 IDLE: with a single requester active, SHALL grant it; with both active, SHALL grant the requester not in last_grant (round-robin).
REQ-020 IDLE grant cycle: SHALL assert s_ready[g]=1 combinationally, latch s_addr[g], s_len[g] and g, and go to ADDR next cycle.
REQ-021 ADDR: SHALL drive m_arvalid=1 with the latched address, length and m_arid=g, all stable until m_arready, and go to DATA on handshake.
REQ-022 DATA: SHALL set m_rready=s_rready[g], s_rvalid[g]=m_rvalid, s_rdata=m_rdata, s_rlast=m_rlast and s_rerr=(m_rresp!=0), with zero-cycle pass-through; s_rvalid of the non-granted requester SHALL be 0.
REQ-023 SHALL count accepted beats in a LEN_WIDTH+1 counter cleared on entering DATA.
REQ-024 On a beat handshake with m_rlast=1, SHALL go to IDLE, set last_grant=g, and grant no new request in that same cycle.
REQ-025 If m_rlast arrives with count!=len, or count reaches len without m_rlast, SHALL set proto_err=1 (sticky until reset) and end the burst on m_rlast only.
REQ-026 SHALL ignore m_rid and s_req changes after the grant, since the request is already latched.
REQ-027 SHALL hold m_arvalid=0 and m_rready=0 in IDLE; s_ready SHALL be 0 outside IDLE.
REQ-028 SHALL let a requester deasserting s_rready stall the bus via m_rready=0, with no beat loss.

Reset
REQ-029 On rst=0, SHALL asynchronously force state=IDLE, last_grant=1 (ICache wins first tie), beat count=0, proto_err=0, and latched addr/len/g=0.
REQ-030 During reset, SHALL drive all outputs to 0; reset mid-burst SHALL abandon the burst with no replay.

Structure
REQ-031 SHALL declare the FSM state enum (IDLE, ADDR, DATA) and the requester index constants (REQ_ICACHE=0, REQ_DCACHE=1) in the shared bundles package.
REQ-032 SHALL instantiate one sub-module, rr_arbiter2 (2-way round-robin arbiter: request, last_grant -> one-hot grant), with the FSM kept in the top module.

Verification
REQ-033 SHALL cover: s_req=01, s_addr[0]=0x8000_0000, s_len[0]=3, m_arready=1, 4 beats -> m_araddr=0x8000_0000, m_arid=0, 4 beats to ICache, s_rlast on beat 4, proto_err=0.
REQ-034 SHALL cover: s_req=11 out of reset -> ICache granted first; after its rlast, s_req still 11 -> DCache granted, m_arid=1.
REQ-035 SHALL cover: m_arready held 0 for 5 cycles -> m_araddr, m_arlen and m_arid stable while m_arvalid=1; no second s_ready.
REQ-036 SHALL cover: s_rready[g]=0 for 3 cycles mid-burst -> m_rready=0 throughout; all 4 beats delivered in order.
REQ-037 SHALL cover: len=3 with m_rlast on beat 2 -> proto_err=1, FSM back in IDLE; a beat with m_rresp=2 -> s_rerr=1 on that beat.
REQ-038 SHALL cover: rst=0 asserted in DATA after beat 1 -> outputs 0 immediately; after release, new request accepted normally.
